adc_frame_packer: RTL
=====================

# adc_frame_packer

Packs 16-bit AD9826 pixel samples into 32-bit, PS-endian words and writes them into the pldata BRAM port as one frame per start request. Sits between the AD9826 capture block and the pldata RAM. It counts pixels per frame, pads odd-length frames, and raises a one-cycle frame-done pulse for the PS interrupt/GPIO path.

## Interface
- `ADDR_W`, 10: BRAM byte-address width.
- `MAX_WORDS`, 256: BRAM capacity in 32-bit words; writes beyond it are dropped.
- `clk` in 1: pixel clock (5 MHz ADC domain).
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `frame_start_in` in 1: one-cycle pulse that arms a frame.
- `frame_len_in` in 10: pixels per frame, sampled on `frame_start_in`. 0 is treated as 1.
- `pix_data_in` in 16: pixel sample.
- `pix_valid_in` in 1: `pix_data_in` is valid this cycle. There is no backpressure.
- `test_mode_in` in 1: selects the internal ramp. It is ignored unless the macro is defined.
- `ram_wr_o` out 1: BRAM write strobe (all 4 byte lanes).
- `ram_addr_o` out `ADDR_W`: byte address, always a multiple of 4.
- `ram_data_o` out 32: packed word.
- `frame_done_o` out 1: one-cycle pulse after the last word is written.
- `busy_o` out 1: high from the cycle after the accepted start until `frame_done_o`.
- `overflow_o` out 1: sticky error flag. Cleared by `rst` or by an accepted `frame_start_in`.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- **IDLE**
  - `frame_start_in` latches `len` (0 maps to 1) and clears the pixel count, the word address, the half-word flag and `overflow_o`.
  - Next state is RUN.
  - Pixels arriving in IDLE are discarded.
- **RUN**, on each `pix_valid_in`:
  - Even pixel index: the pixel goes into the holding register `p0`.
  - Odd pixel index: the word is {p0[7:0], p0[15:8], pix[7:0], pix[15:8]} and is written at the current address. The address then advances by 4.
  - The pixel count increments once per accepted pixel.
  - When the accepted count reaches `len`: an even `len` goes to DONE; an odd `len` goes to FLUSH.
- **FLUSH**: writes {p0[7:0], p0[15:8], 16'h0000}, with no dependence on `pix_valid_in`, then goes to DONE.
- **DONE**: asserts `frame_done_o` for one cycle, deasserts `busy_o`, then returns to IDLE.
- **Capacity limit**: a write whose word index is ≥ `MAX_WORDS` is suppressed (`ram_wr_o` stays 0) and sets `overflow_o`. Counting continues and the frame still completes with `frame_done_o`. The address saturates; it does not wrap.
- **Start outside IDLE**: `frame_start_in` in RUN, FLUSH or DONE is ignored.
- **Start and pixel in the same cycle in IDLE**: that pixel is discarded; only later pixels count.
- **Reset mid-frame**: immediate return to IDLE. No flush write and no `frame_done_o`.

## Timing
- Every output resets to 0: `ram_wr_o`, `ram_addr_o`, `ram_data_o`, `frame_done_o`, `busy_o`, `overflow_o`.
- All outputs are registered.
- `ram_wr_o`, `ram_addr_o` and `ram_data_o` are valid the cycle after the odd pixel is sampled (1-cycle latency).
- The flush write occurs the cycle after FLUSH is entered, which is 2 cycles after the last pixel.
- `frame_done_o` is asserted the cycle after the last write. The earliest re-arm is the cycle after `frame_done_o`.
- Minimum frame period: `len` valid cycles + 3.

## Configuration
- Macro: `ADC_FRAME_PACKER_TESTPAT_EN`.
- **Defined**:
  - When `test_mode_in` = 1, pixel data is replaced by an internal 16-bit ramp and a pixel is presented every cycle while in RUN (`pix_valid_in` is ignored).
  - The ramp is cleared to 16'h0000 on an accepted start and increments by 1 per pixel.
  - When `test_mode_in` = 0, behaviour is as without the macro.
- **Not defined**: no ramp logic is built, `test_mode_in` is unused, and data always comes from `pix_data_in`.

## Test plan
- **Even frame**:
  - Stimulus: len=4; pixels 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 on consecutive cycles.
  - Required response: writes 32'h34127856 @0 and 32'hBC9AF0DE @4, then one `frame_done_o`, with `overflow_o`=0.
- **Odd frame**:
  - Stimulus: len=3; pixels 16'h0102, 16'h0304, 16'h0506.
  - Required response: writes 32'h02010403 @0, then the flush 32'h06050000 @4 two cycles after the last pixel, then `frame_done_o`.
- **Gapped input**:
  - Stimulus: len=2 with `pix_valid_in` high only every 3rd cycle.
  - Required response: exactly one write, 1 cycle after the second pixel; `busy_o` is high throughout.
- **Overflow**:
  - Stimulus: `MAX_WORDS`=2, len=6.
  - Required response: writes @0 and @4 only, `overflow_o` goes to 1, `frame_done_o` still pulses, and the next start clears `overflow_o`.
- **Reset and restart**:
  - Stimulus: assert `rst` after the 3rd pixel of a len=8 frame, release it, then start len=2.
  - Required response: all outputs are 0 during reset, no `frame_done_o` for the aborted frame, and the new frame writes @0.
- **Test pattern** (with `ADC_FRAME_PACKER_TESTPAT_EN` defined):
  - Stimulus: `test_mode_in`=1, len=4.
  - Required response: writes 32'h00000100 @0 and 32'h02000300 @4 on back-to-back odd cycles, then `frame_done_o`.

Source files
------------

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs 16-bit AD9826 pixels into byte-swapped 32-bit words
// and writes one frame per start request into the pldata BRAM port.
// Odd-length frames are padded with a zero half-word. Writes past MAX_WORDS
// are dropped and raise a sticky overflow flag.
// Optional macro ADC_FRAME_PACKER_TESTPAT_EN adds an internal 16-bit ramp
// source selected by test_mode_in.
module adc_frame_packer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_in,
  input  logic [9:0]        frame_len_in,
  input  logic [15:0]       pix_data_in,
  input  logic              pix_valid_in,
  input  logic              test_mode_in,
  output logic              ram_wr_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int unsigned LEN_W  = 10;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // PS side expects each 16-bit sample byte-swapped
  function automatic logic [PIX_W-1:0] swap_bytes(input logic [PIX_W-1:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  state_t              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_pix_cnt;
  logic [PIX_W-1:0]    r_p0;
  logic [IDX_W-1:0]    r_word_idx;

  logic                w_valid;
  logic [PIX_W-1:0]    w_pix;
  logic [LEN_W-1:0]    w_len_eff;
  logic                w_last;
  logic                w_room;
  logic                w_wr_req;
  logic [WORD_W-1:0]   w_wr_word;

`ifdef ADC_FRAME_PACKER_TESTPAT_EN
  logic [PIX_W-1:0]    r_ramp;

  assign w_valid = test_mode_in ? 1'b1 : pix_valid_in;
  assign w_pix   = test_mode_in ? r_ramp : pix_data_in;

  // Ramp source: cleared on an accepted start, one step per pixel in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ramp <= '0;
    end else if (r_state == S_IDLE && frame_start_in) begin
      r_ramp <= '0;
    end else if (r_state == S_RUN && test_mode_in) begin
      r_ramp <= r_ramp + PIX_W'(1);
    end
  end
`else
  logic                w_unused_test_mode;

  assign w_valid            = pix_valid_in;
  assign w_pix              = pix_data_in;
  assign w_unused_test_mode = test_mode_in;
`endif

  assign w_len_eff = (frame_len_in == '0) ? LEN_W'(1) : frame_len_in;
  assign w_last    = (r_pix_cnt + LEN_W'(1)) == r_len;
  assign w_room    = 32'(r_word_idx) < MAX_WORDS;

  // Word to write this cycle: pair completion in RUN, zero-padded half in FLUSH
  always_comb begin
    w_wr_req  = 1'b0;
    w_wr_word = {swap_bytes(r_p0), swap_bytes(w_pix)};
    if (r_state == S_RUN && w_valid && r_pix_cnt[0]) begin
      w_wr_req = 1'b1;
    end
    if (r_state == S_FLUSH) begin
      w_wr_req  = 1'b1;
      w_wr_word = {swap_bytes(r_p0), 16'h0000};
    end
  end

  // Frame FSM with registered BRAM port and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_pix_cnt    <= '0;
      r_p0         <= '0;
      r_word_idx   <= '0;
      ram_wr_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      ram_wr_o     <= 1'b0;
      frame_done_o <= 1'b0;

      // Word index saturates at capacity; dropped writes flag overflow
      if (w_wr_req) begin
        if (w_room) begin
          ram_wr_o   <= 1'b1;
          ram_addr_o <= {r_word_idx[ADDR_W-3:0], 2'b00};
          ram_data_o <= w_wr_word;
          r_word_idx <= r_word_idx + IDX_W'(1);
        end else begin
          overflow_o <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (frame_start_in) begin
            r_len      <= w_len_eff;
            r_pix_cnt  <= '0;
            r_word_idx <= '0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_valid) begin
            if (!r_pix_cnt[0]) begin
              r_p0 <= w_pix;
            end
            r_pix_cnt <= r_pix_cnt + LEN_W'(1);
            if (w_last) begin
              r_state <= r_len[0] ? S_FLUSH : S_DONE;
            end
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          frame_done_o <= 1'b1;
          busy_o       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
